// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents never reset.
// Latency: read data appears one edge after rd_en; only the read register is reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wr_dat,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[idx] <= wr_dat;
    end
  end

  // A failed load leaves zero behind so the error ack never shows stale data.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rd_dat <= '0;
    end else if (rd_clr) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one access per request, ack pulse LATENCY+1 cycles after acceptance.
// Backpressure: ready_o only in IDLE; optional DMEM_MISALIGN_CHECK_EN rejects unaligned addresses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, access;
  logic              we_q, err_q, bad_addr;
  logic [DATA_W-1:0] addr_q, wdata_q, arr_rdat;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign bad_addr = (addr_q[DATA_W-1:AW+2] != '0) || (addr_q[1:0] != 2'b00);
`else
  assign bad_addr = (addr_q[DATA_W-1:AW+2] != '0);
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr_q[1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (access) begin
        err_q <= bad_addr;
      end
    end
  end

  // Reset on the access edge wins: the abandoned store must not land.
  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_en  (access && we_q && !bad_addr && rst_i),
    .rd_en  (access && !we_q && !bad_addr),
    .rd_clr (access && !we_q && bad_addr),
    .idx    (addr_q[AW+1:2]),
    .wr_dat (wdata_q),
    .rd_dat (arr_rdat)
  );

  assign ready_o = (state_q == IDLE);
  assign ack_o   = (state_q == RESP);
  assign err_o   = ack_o && err_q;
  assign rdata_o = (ack_o && we_q) ? '0 : arr_rdat;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboarded bench for data_mem_responder (LATENCY 2 main instance, 1 and 15 for timing).
module tb_data_mem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req1 = 1'b0, req15 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready_o, ack_o, err_o;
  logic [31:0] rdata_o;
  logic        rdy1, ack1, err1, rdy15, ack15, err15;
  logic [31:0] rdata1, rdata15;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          ack_cnt  = 0;
  bit          mon_en   = 0;
  exp_t        q[$];
  logic [31:0] model [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(rdy1), .ack_o(ack1), .rdata_o(rdata1), .err_o(err1));

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(15)) dut_l15 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req15), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(rdy15), .ack_o(ack15), .rdata_o(rdata15), .err_o(err15));

  // Scoreboard: every ack of the main instance must match the oldest expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (!ack_o && err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL err_idle: err_o=%b without ack, required 0", err_o);
      end
      if (ack_o === 1'b1) begin
        ack_cnt++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack: ack_o=1 at cycle %0d with nothing outstanding", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rdata_o !== e.rdata || err_o !== e.err || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL ack: rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                     rdata_o, err_o, cyc, e.rdata, e.err, e.cyc);
          end
        end
      end
    end
  end

  // Called at the negedge of the accepting cycle; also advances the reference memory.
  function automatic void expect_txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic bad;
    int   idx;
    bad = (a >= DEPTH * 4);
`ifdef DMEM_MISALIGN_CHECK_EN
    bad = bad || (a[1:0] != 2'b00);
`endif
    idx     = int'(a[AW+1:2]);
    e.err   = bad;
    e.cyc   = cyc + LAT + 1;
    e.rdata = 32'h0;
    if (w && !bad) model[idx] = d;
    if (!w && !bad) e.rdata = model.exists(idx) ? model[idx] : 32'hx;
    q.push_back(e);
  endfunction

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input bit track);
    int guard;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    guard = 0;
    while (ready_o !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: ready_o=%b, required 1 within 100 cycles", ready_o);
      req = 1'b0;
      return;
    end
    if (track) expect_txn(w, a, d);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d acks still outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 4;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", ready_o); end
    if (ack_o !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b, required 0", ack_o); end
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b, required 0", err_o); end
    if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h, required 0", rdata_o); end
    rst_n = 1'b1;
    mon_en = 1;
  endtask

  task automatic test_store_load();
    send(1'b1, 32'h10, 32'hDEADBEEF, 1);
    send(1'b0, 32'h10, 32'h0, 1);
    send(1'b1, 32'h3FC, 32'hA5A5_5A5A, 1);
    send(1'b0, 32'h3FC, 32'h0, 1);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, d;
      a = 32'($urandom_range(8, 200)) << 2;
      d = $urandom;
      send(1'b1, a, d, 1);
      send(1'b0, a, 32'h0, 1);
    end
    wait_drain();
  endtask

  task automatic test_out_of_range();
    send(1'b1, 32'h0, 32'h1234_5678, 1);
    send(1'b0, 32'h400, 32'h0, 1);
    send(1'b1, 32'h400, 32'hFFFF_0000, 1);
    send(1'b0, 32'hFFFF_FFFC, 32'h0, 1);
    send(1'b0, 32'h0, 32'h0, 1);
    wait_drain();
  endtask

  task automatic test_misalign();
    send(1'b1, 32'h10, 32'h1111_1111, 1);
    send(1'b1, 32'h13, 32'h2222_2222, 1);
    send(1'b0, 32'h10, 32'h0, 1);
    send(1'b0, 32'h12, 32'h0, 1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] list [3];
    int start_acks;
    list[0] = 32'h10; list[1] = 32'h3FC; list[2] = 32'h0;
    start_acks = ack_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr = list[i];
      if (i > 0) @(negedge clk);
      n_checks++;
      if (ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready_accept: got %b, required 1 for request %0d", ready_o, i);
      end
      expect_txn(1'b0, list[i], 32'h0);
      @(posedge clk);
      #1 if (i == 2) req = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
        @(negedge clk);
        n_checks++;
        if (ready_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ready_busy: got %b, required 0 at %0d cycles after acceptance", ready_o, k);
        end
      end
    end
    wait_drain();
    repeat (4) @(negedge clk);
    n_checks++;
    if (ack_cnt - start_acks != 3) begin
      n_fail++;
      $display("FAIL b2b_ack_count: got %0d, required 3", ack_cnt - start_acks);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 32'h20, 32'hAAAA_0000, 1);
    wait_drain();
    send(1'b1, 32'h20, 32'hBBBB_1111, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", ready_o); end
    if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h, required 0", rdata_o); end
    repeat (6) @(negedge clk);
    send(1'b0, 32'h20, 32'h0, 1);
    wait_drain();
  endtask

  task automatic test_latency();
    for (int s = 0; s < 2; s++) begin
      for (int op = 0; op < 2; op++) begin
        int lat, n0, got;
        logic [31:0] dat;
        logic e;
        lat = (s == 0) ? 1 : 15;
        @(negedge clk);
        we = (op == 0); addr = 32'h8; wdata = 32'hCAFE_F00D;
        n_checks++;
        if (((s == 0) ? rdy1 : rdy15) !== 1'b1) begin
          n_fail++;
          $display("FAIL lat%0d_ready: got 0, required 1", lat);
        end
        n0 = cyc;
        if (s == 0) req1 = 1'b1; else req15 = 1'b1;
        @(posedge clk);
        #1 begin req1 = 1'b0; req15 = 1'b0; end
        got = -1; dat = 'x; e = 1'bx;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (((s == 0) ? ack1 : ack15) === 1'b1) begin
            got = cyc;
            dat = (s == 0) ? rdata1 : rdata15;
            e   = (s == 0) ? err1 : err15;
            break;
          end
        end
        n_checks++;
        if (got != n0 + lat + 1 || e !== 1'b0) begin
          n_fail++;
          $display("FAIL lat%0d_ack: ack at cycle %0d err=%b, required cycle %0d err=0",
                   lat, got, e, n0 + lat + 1);
        end
        n_checks++;
        if (dat !== ((op == 0) ? 32'h0 : 32'hCAFE_F00D)) begin
          n_fail++;
          $display("FAIL lat%0d_rdata: got %h, required %h", lat, dat,
                   (op == 0) ? 32'h0 : 32'hCAFE_F00D);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_out_of_range();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_latency();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, sets the number of 32-bit words of storage; it shall be a power of two.
REQ-002 Parameter LATENCY, default 2, sets the number of wait cycles between request acceptance and the access; legal range is 1..15.
REQ-003 clk_i  input  1  is the single clock; all state shall update on its rising edge.
REQ-004 rst_i  input  1  is the reset: synchronous, active-low.
REQ-005 req_i  input  1  indicates the CPU-side initiator is requesting a data-memory access.
REQ-006 we_i  input  1  selects the access type: 1 = store, 0 = load.
REQ-007 addr_i  input  32  is the byte address.
REQ-008 wdata_i  input  32  is the store data.
REQ-009 ready_o  output  1  indicates the block can accept a request this cycle.
REQ-010 ack_o  output  1  is a one-cycle completion pulse.
REQ-011 rdata_o  output  32  is the load data, valid while ack_o is high.
REQ-012 err_o  output  1  flags a failed access, valid while ack_o is high.

Function
REQ-013 The FSM shall have three states: IDLE, WAIT and RESP.
REQ-014 ready_o shall be 1 exactly when the state is IDLE.
REQ-015 IDLE: when req_i=1, the block shall latch we_i, addr_i and wdata_i, load the counter with LATENCY-1, and go to WAIT.
REQ-016 WAIT: the counter shall decrement each cycle; when it is 0, the block shall perform the access at that edge and go to RESP.
REQ-017 RESP: ack_o shall be 1 for exactly one cycle, then the FSM shall return to IDLE; ready_o shall be 0 during RESP, so back-to-back requests are spaced by at least LATENCY+2 cycles.
REQ-018 For a request accepted at the edge ending cycle N, ack_o shall be high in cycle N+LATENCY+1.
REQ-019 req_i and all other inputs shall be ignored while the state is not IDLE; latched values shall not change until the next acceptance.
REQ-020 The word index shall be addr[log2(DEPTH)+1:2]; an address at or above DEPTH*4 shall give err_o=1 and rdata_o=0, with no write.
REQ-021 Load: rdata_o shall be registered from storage at the access edge and held until the next acknowledged load.
REQ-022 Store: the full 32-bit word shall be written at the access edge; rdata_o shall be 0 on a store ack.
REQ-023 A store followed by a load to the same address shall return the stored data.
REQ-024 err_o shall be 0 whenever ack_o is 0.

Reset
REQ-025 While rst_i=0 at a rising edge: state shall go to IDLE, the counter to 0, and ack_o, err_o and rdata_o to 0.
REQ-026 A reset asserted mid-transaction shall abandon it: no write if the access edge has not occurred, and no ack.
REQ-027 Storage contents shall not be reset.

Configuration
REQ-028 With DMEM_MISALIGN_CHECK_EN defined, addr[1:0]!=0 shall give err_o=1 with ack, no write, and rdata_o=0.
REQ-029 Without DMEM_MISALIGN_CHECK_EN, addr[1:0] shall be ignored and the access shall proceed word-aligned.

Structure
REQ-030 Package dmem_pkg shall hold the FSM state enum (IDLE/WAIT/RESP), the data width constant (32) and the counter width constant (4).
REQ-031 Storage shall be a sub-module dmem_array: synchronous write, registered read, DEPTH words.

Verification
REQ-032 Store 0xDEADBEEF to 0x10 (LATENCY=2), then load 0x10 -> each ack in cycle N+3, load rdata_o=0xDEADBEEF, err_o=0.
REQ-033 Hold req_i=1 continuously for 3 loads -> exactly 3 acks, with ready_o=0 from acceptance through ack.
REQ-034 Load address 0x400 with DEPTH=256 -> ack with err_o=1, rdata_o=0; a prior word at 0x0 is unchanged.
REQ-035 Store to 0x13: with DMEM_MISALIGN_CHECK_EN -> err_o=1 and word 0x10 unchanged; without it -> word 0x10 written, err_o=0.
REQ-036 Accept a store to 0x20, drive rst_i=0 in the WAIT cycle -> no ack, a later load of 0x20 returns the old value, ready_o=1 after release.
REQ-037 Run with LATENCY=1 and LATENCY=15 -> ack in cycle N+2 and N+16 respectively.
